// File: rtl/link_control.sv
// link_control: game-level sequencer for the character datapath.
// Paces one character action per video frame and hands drawing off to the datapath.
//
// Parameters:
//   FRAME_CYCLES    clock cycles per frame tick
//   ATTACK_FRAMES   attack actions per attack press (>= 1)
//   COOLDOWN_FRAMES frame ticks of attack lockout (cooldown build only)
//
// Optional feature macro: ATTACK_COOLDOWN_EN
//   When defined, a finished attack sequence locks out btn_attack
//   for COOLDOWN_FRAMES frame ticks.
//
// Ports:
//   clock          in   system clock
//   reset          in   synchronous, active-high reset
//   btn_up         in   move-up request
//   btn_down       in   move-down request
//   btn_left       in   move-left request
//   btn_right      in   move-right request
//   btn_attack     in   attack request
//   draw_map_done  in   map draw complete
//   draw_link_done in   character draw complete
//   init           out  initialization strobe
//   idle           out  idle action strobe
//   attack         out  attack action strobe
//   up             out  move-up strobe
//   down           out  move-down strobe
//   left           out  move-left strobe
//   right          out  move-right strobe
//   draw_map       out  map draw request (level)
//   draw_link      out  character draw request (level)
//   frame_overrun  out  one-cycle pulse when a frame tick is dropped

module link_control #(
    parameter int FRAME_CYCLES    = 833333,
    parameter int ATTACK_FRAMES   = 8,
    parameter int COOLDOWN_FRAMES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_attack,
    input  logic draw_map_done,
    input  logic draw_link_done,
    output logic init,
    output logic idle,
    output logic attack,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic draw_map,
    output logic draw_link,
    output logic frame_overrun
);

    localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int AW = (ATTACK_FRAMES > 1) ? $clog2(ATTACK_FRAMES) : 1;

    localparam logic [FW-1:0] FRAME_LAST  = FW'(FRAME_CYCLES - 1);
    localparam logic [AW-1:0] ATTACK_LOAD = AW'(ATTACK_FRAMES - 1);

    // Parameter sanity: an attack press must produce at least one action.
    if (ATTACK_FRAMES < 1 || COOLDOWN_FRAMES < 1 || FRAME_CYCLES < 1) begin : g_bad_param
        $error("link_control: parameters must all be >= 1");
    end

    typedef enum logic [3:0] {
        S_INIT,
        S_DRAW_MAP,
        S_DRAW_LINK,
        S_WAIT,
        S_IDLE,
        S_ATTACK,
        S_UP,
        S_DOWN,
        S_LEFT,
        S_RIGHT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [FW-1:0] frame_cnt;
    logic          frame_tick;
    logic          frame_pending;
    logic          consume;
    logic [AW-1:0] attack_cnt;
    logic [AW-1:0] attack_cnt_next;
    logic          attack_ok;

    // ------------------------------------------------------------------
    // Frame pacing
    // ------------------------------------------------------------------
    assign frame_tick = (frame_cnt == FRAME_LAST);
    assign consume    = (state == S_WAIT) && frame_pending;

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Ticks collapse into a single pending flag. A tick landing while an
    // unconsumed tick is still pending is reported as an overrun; a tick
    // coinciding with consumption simply re-arms the flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_pending <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            frame_overrun <= frame_tick && frame_pending && !consume;
            if (frame_tick) begin
                frame_pending <= 1'b1;
            end else if (consume) begin
                frame_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Attack lockout
    // ------------------------------------------------------------------
`ifdef ATTACK_COOLDOWN_EN
    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CW-1:0] COOLDOWN_LOAD = CW'(COOLDOWN_FRAMES);

    logic [CW-1:0] cooldown_cnt;

    // Loaded on the final attack cycle of a sequence, then drained by ticks.
    always_ff @(posedge clock) begin
        if (reset) begin
            cooldown_cnt <= '0;
        end else if (state == S_ATTACK && attack_cnt == '0) begin
            cooldown_cnt <= COOLDOWN_LOAD;
        end else if (frame_tick && cooldown_cnt != '0) begin
            cooldown_cnt <= cooldown_cnt - 1'b1;
        end
    end

    assign attack_ok = (cooldown_cnt == '0);
`else
    assign attack_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_INIT;
            attack_cnt <= '0;
        end else begin
            state      <= state_next;
            attack_cnt <= attack_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        attack_cnt_next = attack_cnt;
        unique case (state)
            S_INIT: begin
                state_next = S_DRAW_MAP;
            end
            S_DRAW_MAP: begin
                if (draw_map_done) begin
                    state_next = S_DRAW_LINK;
                end
            end
            S_DRAW_LINK: begin
                if (draw_link_done) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // An attack sequence in flight overrides every button.
                if (consume) begin
                    if (attack_cnt != '0) begin
                        state_next      = S_ATTACK;
                        attack_cnt_next = attack_cnt - 1'b1;
                    end else if (btn_attack && attack_ok) begin
                        state_next      = S_ATTACK;
                        attack_cnt_next = ATTACK_LOAD;
                    end else if (btn_up) begin
                        state_next = S_UP;
                    end else if (btn_down) begin
                        state_next = S_DOWN;
                    end else if (btn_left) begin
                        state_next = S_LEFT;
                    end else if (btn_right) begin
                        state_next = S_RIGHT;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_IDLE,
            S_ATTACK,
            S_UP,
            S_DOWN,
            S_LEFT,
            S_RIGHT: begin
                state_next = S_DRAW_MAP;
            end
            default: begin
                state_next = S_INIT;
            end
        endcase
    end

    // Moore command decode: exactly one state per command.
    always_comb begin
        init      = 1'b0;
        idle      = 1'b0;
        attack    = 1'b0;
        up        = 1'b0;
        down      = 1'b0;
        left      = 1'b0;
        right     = 1'b0;
        draw_map  = 1'b0;
        draw_link = 1'b0;
        unique case (state)
            S_INIT:      init      = 1'b1;
            S_DRAW_MAP:  draw_map  = 1'b1;
            S_DRAW_LINK: draw_link = 1'b1;
            S_IDLE:      idle      = 1'b1;
            S_ATTACK:    attack    = 1'b1;
            S_UP:        up        = 1'b1;
            S_DOWN:      down      = 1'b1;
            S_LEFT:      left      = 1'b1;
            S_RIGHT:     right     = 1'b1;
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_link_control.sv
// tb_link_control: directed self-checking bench for link_control.
// Small frame/attack parameters; datapath model answers draw requests after 5 cycles.

module tb_link_control;

    localparam logic [5:0] A_IDLE = 6'b100000;
    localparam logic [5:0] A_ATK  = 6'b010000;
    localparam logic [5:0] A_UP   = 6'b001000;
    localparam logic [5:0] A_LT   = 6'b000010;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic btn_up = 1'b0;
    logic btn_down = 1'b0;
    logic btn_left = 1'b0;
    logic btn_right = 1'b0;
    logic btn_attack = 1'b0;
    logic draw_map_done;
    logic draw_link_done;
    logic init;
    logic idle;
    logic attack;
    logic up;
    logic down;
    logic left;
    logic right;
    logic draw_map;
    logic draw_link;
    logic frame_overrun;

    int total = 0;
    int bad = 0;
    int map_delay = 5;
    int map_cnt = 0;
    int link_cnt = 0;
    int ovr_cnt = 0;
    int onehot_bad = 0;

    link_control #(
        .FRAME_CYCLES   (16),
        .ATTACK_FRAMES  (3),
        .COOLDOWN_FRAMES(4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_attack    (btn_attack),
        .draw_map_done (draw_map_done),
        .draw_link_done(draw_link_done),
        .init          (init),
        .idle          (idle),
        .attack        (attack),
        .up            (up),
        .down          (down),
        .left          (left),
        .right         (right),
        .draw_map      (draw_map),
        .draw_link     (draw_link),
        .frame_overrun (frame_overrun)
    );

    always #5 clock = ~clock;

    // Datapath model: done rises on the last cycle of a map_delay / 5 cycle request.
    always @(posedge clock) begin
        map_cnt  <= draw_map ? map_cnt + 1 : 0;
        link_cnt <= draw_link ? link_cnt + 1 : 0;
    end

    assign draw_map_done  = draw_map && (map_cnt >= map_delay - 1);
    assign draw_link_done = draw_link && (link_cnt >= 4);

    always @(negedge clock) begin
        if (frame_overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
        if ($countones({init, idle, attack, up, down, left, right,
                        draw_map, draw_link}) > 1)
            onehot_bad <= onehot_bad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_action(output logic [5:0] act, output int n);
        act = 6'd0;
        n = 0;
        while (act == 6'd0 && n < 200) begin
            @(negedge clock);
            n++;
            act = {idle, attack, up, down, left, right};
        end
        if (act == 6'd0) begin
            total++;
            bad++;
            $error("FAIL wait_action: observed=timeout expected=action");
        end
    endtask

    initial begin
        logic [5:0] a;
        int n;
        int base;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_init", init, 1);
        chk("rst_cmds", {idle, attack, up, down, left, right,
                         draw_map, draw_link}, 0);
        chk("rst_ovr", frame_overrun, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("init_drop", init, 0);
        chk("map_rise", draw_map, 1);

        n = 0;
        while (draw_map === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("map_len", n, 5);
        chk("link_rise", draw_link, 1);
        n = 0;
        while (draw_link === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("link_len", n, 5);
        chk("wait_cmds", {init, idle, attack, up, down, left, right,
                          draw_map, draw_link}, 0);
        wait_action(a, n);
        chk("first_gap", n, 6);
        chk("first_act", a, A_IDLE);

        // Up beats down
        btn_up = 1'b1;
        btn_down = 1'b1;
        wait_action(a, n);
        chk("updn_gap", n, 16);
        chk("updn_1", a, A_UP);
        wait_action(a, n);
        chk("updn_2", a, A_UP);
        wait_action(a, n);
        chk("updn_3", a, A_UP);
        btn_up = 1'b0;
        btn_down = 1'b0;
        wait_action(a, n);
        chk("rel_1", a, A_IDLE);
        wait_action(a, n);
        chk("rel_2", a, A_IDLE);

        // Left beats right
        btn_left = 1'b1;
        btn_right = 1'b1;
        wait_action(a, n);
        chk("lfrt", a, A_LT);
        btn_left = 1'b0;
        btn_right = 1'b0;

        // One-frame attack press with left held throughout
        btn_attack = 1'b1;
        btn_left = 1'b1;
        wait_action(a, n);
        chk("atk_1", a, A_ATK);
        btn_attack = 1'b0;
        wait_action(a, n);
        chk("atk_2", a, A_ATK);
        wait_action(a, n);
        chk("atk_3", a, A_ATK);
        wait_action(a, n);
        chk("atk_left_1", a, A_LT);
        wait_action(a, n);
        chk("atk_left_2", a, A_LT);
        btn_left = 1'b0;

        // Map draw stall of 41 cycles spans two extra ticks
        base = ovr_cnt;
        map_delay = 41;
        wait_action(a, n);
        map_delay = 5;
        chk("stall_gap", n, 48);
        chk("stall_act", a, A_IDLE);
        chk("stall_ovr", ovr_cnt - base, 2);
        wait_action(a, n);
        chk("post_gap", n, 16);
        chk("post_act", a, A_IDLE);
        chk("post_ovr", ovr_cnt - base, 2);

        // Reset during character draw, mid-attack
        btn_attack = 1'b1;
        wait_action(a, n);
        chk("ra_atk", a, A_ATK);
        btn_attack = 1'b0;
        n = 0;
        while (draw_link !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("ra_link", draw_link, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("ra_init", init, 1);
        chk("ra_cmds", {idle, attack, up, down, left, right,
                        draw_map, draw_link}, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("ra_map", draw_map, 1);
        wait_action(a, n);
        chk("ra_gap", n, 16);
        chk("ra_act", a, A_IDLE);

        // Held attack
        btn_attack = 1'b1;
`ifdef ATTACK_COOLDOWN_EN
        for (int i = 0; i < 3; i++) begin
            wait_action(a, n);
            chk("hold_atk", a, A_ATK);
        end
        wait_action(a, n);
        chk("hold_cool", a, A_IDLE);
`else
        for (int i = 0; i < 6; i++) begin
            wait_action(a, n);
            chk("hold_atk", a, A_ATK);
        end
`endif
        btn_attack = 1'b0;
        wait_action(a, n);
        chk("hold_rel", a, A_IDLE);

        chk("onehot", onehot_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
